// File: rtl/i2c_slave_regif_if.sv
// Register-port bundle between the I2C target and the register file it drives.
// Latency: n/a (wires only). Backpressure: none; strobes are single-cycle, read data is
// expected one clk after reg_rd. Ports: reg_addr/reg_wdata/reg_wr/reg_rd out of the target, reg_rdata in.
interface i2c_slave_regif_if;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [7:0]  reg_rdata;

  // master: the I2C target that issues register accesses
  modport master (output reg_addr, reg_wdata, reg_wr, reg_rd, input reg_rdata);
  // slave: the register file answering them
  modport slave  (input reg_addr, reg_wdata, reg_wr, reg_rd, output reg_rdata);
endinterface

// File: rtl/i2c_slave_regif.sv
// I2C target (7-bit device address, 16-bit register pointer, 8-bit data) driving a register port.
// Latency: SYNC_STAGES+1 clks from pad to bus decode (+FILT_LEN with I2C_SLAVE_GLITCH_FILT_EN defined).
// Backpressure: none; no clock stretching, register port must answer reg_rd one clk later.
// Ports: clk, rst_n (async active-low), scl_in/sda_in raw pads, sda_out_en (1 = pull SDA low),
// busy (addressed until STOP/START/mismatch), rif = register port (addr, wdata, wr, rd, rdata).
module i2c_slave_regif #(
  parameter logic [6:0] DEVICE_ID   = 7'h2B,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILT_LEN    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_out_en,
  output logic              busy,
  i2c_slave_regif_if.master rif
);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, ADH, ADH_ACK, ADL, ADL_ACK, WR, WR_ACK, RD, RD_ACK, WAIT
  } state_t;

  // ---------------------------------------------------------------- input conditioning
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_s, sda_s;

  // Preset to 1 so a released bus looks idle straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILT_EN
  localparam int FCW = $clog2(FILT_LEN + 1);
  logic [1:0]     raw_s;
  logic [1:0]     filt_q;
  logic [FCW-1:0] fcnt_q [2];

  assign raw_s = {scl_sync_q[SYNC_STAGES-1], sda_sync_q[SYNC_STAGES-1]};

  // The filtered copy follows the raw value only after FILT_LEN consecutive clks of disagreement;
  // any return to agreement restarts the count, so shorter pulses vanish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw_s[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FCW'(FILT_LEN - 1)) begin
          filt_q[i] <= raw_s[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign scl_s = filt_q[1];
  assign sda_s = filt_q[0];
`else
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
`endif

  // ---------------------------------------------------------------- edge / condition detect
  logic scl_d_q, sda_d_q;
  logic scl_rise, scl_fall, start_c, stop_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_d_q <= 1'b1;
      sda_d_q <= 1'b1;
    end else begin
      scl_d_q <= scl_s;
      sda_d_q <= sda_s;
    end
  end

  assign scl_rise = scl_s & ~scl_d_q;
  assign scl_fall = ~scl_s & scl_d_q;
  // SCL must be high on both sides so an SDA move at an SCL edge is not mistaken for a condition.
  assign start_c  = scl_s & scl_d_q & sda_d_q & ~sda_s;
  assign stop_c   = scl_s & scl_d_q & ~sda_d_q & sda_s;

  // ---------------------------------------------------------------- protocol FSM
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;        // bit count in byte states, ACK phase in *_ACK states
  logic [7:0]  shreg_q, shreg_d;    // receive shift register
  logic [7:0]  tx_q, tx_d;          // transmit shift register
  logic        rw_q, rw_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic        rd_pend_q, rd_pend_d;
  logic [7:0]  rx_byte;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = 1'b0;
    rd_d      = 1'b0;
    rd_pend_d = rd_q;
    rx_byte   = {shreg_q[6:0], sda_s};

    // Pointer bumps the clk after a write strobe, and when prefetched read data is captured.
    if (wr_q) addr_d = addr_q + 16'd1;
    if (rd_pend_q) begin
      tx_d   = rif.reg_rdata;
      addr_d = addr_q + 16'd1;
    end

    if (start_c) begin
      state_d = DEV;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (stop_c) begin
      state_d = IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        DEV, ADH, ADL, WR: begin
          if (scl_rise) begin
            shreg_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = '0;
              case (state_q)
                DEV: begin
                  if (rx_byte[7:1] == DEVICE_ID) begin
                    state_d = DEV_ACK;
                    busy_d  = 1'b1;
                    rw_d    = rx_byte[0];
                  end else begin
                    state_d = WAIT;
                  end
                end
                ADH: begin
                  addr_d[15:8] = rx_byte;
                  state_d      = ADH_ACK;
                end
                ADL: begin
                  addr_d[7:0] = rx_byte;
                  state_d     = ADL_ACK;
                end
                default: begin
                  wdata_d = rx_byte;
                  wr_d    = 1'b1;
                  state_d = WR_ACK;
                end
              endcase
            end
          end
        end

        // Phase 0: wait for the fall after bit 8 and pull SDA; phase 1: 9th rise;
        // phase 2: the following fall releases SDA (or drives the first read bit).
        DEV_ACK, ADH_ACK, ADL_ACK, WR_ACK: begin
          if (scl_fall && cnt_q == 4'd0) begin
            oe_d  = 1'b1;
            cnt_d = 4'd1;
          end else if (scl_rise && cnt_q == 4'd1) begin
            cnt_d = 4'd2;
            if (state_q == DEV_ACK && rw_q) rd_d = 1'b1;
          end else if (scl_fall && cnt_q == 4'd2) begin
            cnt_d = '0;
            oe_d  = 1'b0;
            case (state_q)
              DEV_ACK: begin
                if (rw_q) begin
                  state_d = RD;
                  oe_d    = ~tx_q[7];
                  tx_d    = {tx_q[6:0], 1'b0};
                end else begin
                  state_d = ADH;
                end
              end
              ADH_ACK: state_d = ADL;
              default: state_d = WR;
            endcase
          end
        end

        RD: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              cnt_d   = 4'd1;
              state_d = RD_ACK;
            end else begin
              oe_d = ~tx_q[7];
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end

        RD_ACK: begin
          if (scl_rise && cnt_q == 4'd1) begin
            if (!sda_s) begin
              rd_d  = 1'b1;
              cnt_d = 4'd2;
            end else begin
              state_d = WAIT;      // NACK: stay busy until the master ends the transfer
            end
          end else if (scl_fall && cnt_q == 4'd2) begin
            state_d = RD;
            cnt_d   = '0;
            oe_d    = ~tx_q[7];
            tx_d    = {tx_q[6:0], 1'b0};
          end
        end

        default: ;                 // IDLE, WAIT: only START/STOP matter
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      tx_q      <= '0;
      rw_q      <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      rw_q      <= rw_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign sda_out_en    = oe_q;
  assign busy          = busy_q;
  assign rif.reg_addr  = addr_q;
  assign rif.reg_wdata = wdata_q;
  assign rif.reg_wr    = wr_q;
  assign rif.reg_rd    = rd_q;

endmodule

// File: tb/tb_i2c_slave_regif.sv
`timescale 1ns/1ps
// Bench for i2c_slave_regif: bus-master tasks drive directed transactions; expected register
// strobes go into a scoreboard queue that a separate monitor drains whenever reg_wr/reg_rd fire.
// Bus-visible results (ACK bits, read bytes, busy, sda_out_en) are compared inline.
module tb_i2c_slave_regif;
  localparam int Q = 8;            // clks per quarter SCL period

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_out_en, busy;
  logic sda_bus;

  ev_t        exp_q [$];
  logic [7:0] rdq   [$];
  int checks = 0;
  int errors = 0;

  i2c_slave_regif_if rif ();

  assign sda_bus = sda_m & ~sda_out_en;   // open-drain wired-AND

  i2c_slave_regif #(.DEVICE_ID(7'h2B), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_in     (scl_m),
    .sda_in     (sda_bus),
    .sda_out_en (sda_out_en),
    .busy       (busy),
    .rif        (rif.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back('{wr: 1'b1, addr: a, data: d});
  endtask

  task automatic exp_rd(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back('{wr: 1'b0, addr: a, data: 8'h00});
    rdq.push_back(d);
  endtask

  // Monitor / register-file model: pops one expectation per strobe, answers reads.
  initial begin
    ev_t e;
    rif.reg_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (rif.reg_wr || rif.reg_rd) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: got wr=%b rd=%b addr=%h data=%h, expected none",
                   rif.reg_wr, rif.reg_rd, rif.reg_addr, rif.reg_wdata);
        end else begin
          e = exp_q.pop_front();
          if (rif.reg_wr !== e.wr || rif.reg_rd !== !e.wr || rif.reg_addr !== e.addr ||
              (e.wr && rif.reg_wdata !== e.data)) begin
            errors++;
            $display("FAIL strobe: got wr=%b rd=%b addr=%h data=%h expected wr=%b addr=%h data=%h",
                     rif.reg_wr, rif.reg_rd, rif.reg_addr, rif.reg_wdata, e.wr, e.addr, e.data);
          end
        end
        if (rif.reg_rd) rif.reg_rdata = (rdq.size() > 0) ? rdq.pop_front() : 8'h00;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- bus-master tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; step(Q);
    scl_m = 1'b1; step(Q);
    sda_m = 1'b0; step(Q);
    scl_m = 1'b0; step(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; step(Q);
    scl_m = 1'b1; step(Q);
    sda_m = 1'b1; step(Q);
  endtask

  // One SCL clock; glitch inserts a 2-clk low pulse into the high phase.
  task automatic xfer_bit(input logic b, input bit glitch, output logic got);
    sda_m = b; step(Q);
    scl_m = 1'b1;
    if (glitch) begin
      step(3); scl_m = 1'b0; step(2); scl_m = 1'b1; step(Q - 5);
    end else begin
      step(Q);
    end
    got = sda_bus;
    step(Q);
    scl_m = 1'b0;
    step(2);
  endtask

  task automatic write_byte(input logic [7:0] b, input int gbit, output logic ack);
    logic got;
    for (int i = 7; i >= 0; i--) xfer_bit(b[i], (i == gbit), got);
    xfer_bit(1'b1, 1'b0, got);
    ack = ~got;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] b);
    logic got;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      xfer_bit(1'b1, 1'b0, got);
      b = {b[6:0], got};
    end
    xfer_bit(~ack, 1'b0, got);
  endtask

  // ---------------------------------------------------------------- directed sequence
  initial begin
    logic       ack;
    logic       got;
    logic [7:0] rb;

    step(4);
    chk("rst_sda_out_en", 32'(sda_out_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_reg_addr", 32'(rif.reg_addr), 32'h0000);
    chk("rst_reg_wdata", 32'(rif.reg_wdata), 32'h00);
    chk("rst_reg_wr", 32'(rif.reg_wr), 32'd0);
    chk("rst_reg_rd", 32'(rif.reg_rd), 32'd0);
    rst_n = 1'b1;
    step(4);

    // Write 0xA5, 0x5A at 0x1234
    i2c_start();
    write_byte(8'h56, -1, ack); chk("wr_dev_ack", 32'(ack), 32'd1);
    chk("wr_busy_set", 32'(busy), 32'd1);
    write_byte(8'h12, -1, ack); chk("wr_adh_ack", 32'(ack), 32'd1);
    write_byte(8'h34, -1, ack); chk("wr_adl_ack", 32'(ack), 32'd1);
    exp_wr(16'h1234, 8'hA5);
    write_byte(8'hA5, -1, ack); chk("wr_d0_ack", 32'(ack), 32'd1);
    exp_wr(16'h1235, 8'h5A);
    write_byte(8'h5A, -1, ack); chk("wr_d1_ack", 32'(ack), 32'd1);
    chk("wr_busy_before_stop", 32'(busy), 32'd1);
    i2c_stop(); step(4);
    chk("wr_busy_after_stop", 32'(busy), 32'd0);
    chk("wr_addr_after", 32'(rif.reg_addr), 32'h1236);
    chk("wr_wdata_last", 32'(rif.reg_wdata), 32'h5A);

    // Random read: pointer 0x0010, repeated START, two bytes (ACK, NACK)
    i2c_start();
    write_byte(8'h56, -1, ack); chk("rd_dev_ack", 32'(ack), 32'd1);
    write_byte(8'h00, -1, ack); chk("rd_adh_ack", 32'(ack), 32'd1);
    write_byte(8'h10, -1, ack); chk("rd_adl_ack", 32'(ack), 32'd1);
    exp_rd(16'h0010, 8'hC3);
    exp_rd(16'h0011, 8'h3C);
    i2c_start();
    write_byte(8'h57, -1, ack); chk("rd_dev2_ack", 32'(ack), 32'd1);
    read_byte(1'b1, rb); chk("rd_byte0", 32'(rb), 32'hC3);
    read_byte(1'b0, rb); chk("rd_byte1", 32'(rb), 32'h3C);
    step(Q);
    chk("rd_sda_released", 32'(sda_out_en), 32'd0);
    chk("rd_busy_after_nack", 32'(busy), 32'd1);
    i2c_stop(); step(4);
    chk("rd_busy_after_stop", 32'(busy), 32'd0);
    chk("rd_addr_after", 32'(rif.reg_addr), 32'h0012);

    // Wrong device address: no ACK, not busy, no strobes
    i2c_start();
    write_byte(8'h58, -1, ack); chk("nm_no_ack", 32'(ack), 32'd0);
    chk("nm_busy", 32'(busy), 32'd0);
    write_byte(8'h12, -1, ack); chk("nm_no_ack2", 32'(ack), 32'd0);
    i2c_stop(); step(4);

    // Pointer wrap at 0xFFFF
    i2c_start();
    write_byte(8'h56, -1, ack); chk("wrap_dev_ack", 32'(ack), 32'd1);
    write_byte(8'hFF, -1, ack);
    write_byte(8'hFF, -1, ack);
    exp_wr(16'hFFFF, 8'h11);
    exp_wr(16'h0000, 8'h22);
    exp_wr(16'h0001, 8'h33);
    write_byte(8'h11, -1, ack); chk("wrap_d0_ack", 32'(ack), 32'd1);
    write_byte(8'h22, -1, ack); chk("wrap_d1_ack", 32'(ack), 32'd1);
    write_byte(8'h33, -1, ack); chk("wrap_d2_ack", 32'(ack), 32'd1);
    i2c_stop(); step(4);
    chk("wrap_addr_after", 32'(rif.reg_addr), 32'h0002);

    // Reset while the target drives bit 4 of a read byte (data 0x00 keeps SDA pulled)
    i2c_start();
    write_byte(8'h56, -1, ack);
    write_byte(8'h00, -1, ack);
    write_byte(8'h20, -1, ack);
    exp_rd(16'h0020, 8'h00);
    i2c_start();
    write_byte(8'h57, -1, ack); chk("rst_rd_dev_ack", 32'(ack), 32'd1);
    rb = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      xfer_bit(1'b1, 1'b0, got);
      rb = {rb[6:0], got};
    end
    chk("rst_rd_first_bits", 32'(rb[3:0]), 32'h0);
    step(Q);
    chk("rst_rd_driving", 32'(sda_out_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_rd_release", 32'(sda_out_en), 32'd0);
    chk("rst_rd_busy", 32'(busy), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(2);
    i2c_stop(); step(4);
    i2c_start();
    write_byte(8'h56, -1, ack); chk("post_rst_dev_ack", 32'(ack), 32'd1);
    write_byte(8'h00, -1, ack);
    write_byte(8'h40, -1, ack);
    exp_wr(16'h0040, 8'h77);
    write_byte(8'h77, -1, ack); chk("post_rst_d_ack", 32'(ack), 32'd1);
    i2c_stop(); step(4);
    chk("post_rst_addr", 32'(rif.reg_addr), 32'h0041);

    // 2-clk SCL low glitch during the third bit of data byte 0xA5.
    // Filtered: byte intact. Unfiltered: bit repeated -> 1,0,1,1,0,0,1,0 = 0xB2.
    i2c_start();
    write_byte(8'h56, -1, ack); chk("gl_dev_ack", 32'(ack), 32'd1);
    write_byte(8'h00, -1, ack);
    write_byte(8'h50, -1, ack);
`ifdef I2C_SLAVE_GLITCH_FILT_EN
    exp_wr(16'h0050, 8'hA5);
`else
    exp_wr(16'h0050, 8'hB2);
`endif
    write_byte(8'hA5, 5, ack);
    i2c_stop(); step(4);
    chk("gl_busy_after_stop", 32'(busy), 32'd0);

    step(10);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
